// File: rtl/order_replay_pkg.sv
// Shared constants, state encoding, window entry layout and the window-membership test
// used by the order replay buffer.
package order_replay_pkg;

  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 2 ** ID_W;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    REPLAY = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        key_index;
    logic              target_id;
  } entry_t;

  // An id is outstanding when its distance from head (mod DEPTH) is below count.
  function automatic logic in_window(input logic [ID_W-1:0] id,
                                     input logic [ID_W-1:0] head,
                                     input logic [ID_W:0]   count);
    logic [ID_W-1:0] off;
    off = id - head;
    return {1'b0, off} < count;
  endfunction

endpackage

// File: rtl/order_replay_buffer_if.sv
// Source, dispatch, resend and retire signals of the order replay buffer, bundled for
// the DUT (slave) and for whoever drives it (master).
interface order_replay_buffer_if import order_replay_pkg::*; ();

  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_key_index;
  logic              in_target_id;
  logic              in_vld;
  logic              in_ready;

  logic [DATA_W-1:0] test_data;
  logic              test_data_vld;
  logic [2:0]        key_index;
  logic [ID_W-1:0]   order_id;
  logic              target_id;

  logic              resend_en;
  logic [ID_W-1:0]   resend_id;

  logic              ret_vld;
  logic [ID_W-1:0]   ret_id;

  modport slave (
    input  in_data, in_key_index, in_target_id, in_vld,
    output in_ready,
    output test_data, test_data_vld, key_index, order_id, target_id,
    input  resend_en, resend_id,
    input  ret_vld, ret_id
  );

  modport master (
    output in_data, in_key_index, in_target_id, in_vld,
    input  in_ready,
    input  test_data, test_data_vld, key_index, order_id, target_id,
    output resend_en, resend_id,
    output ret_vld, ret_id
  );

endinterface

// File: rtl/order_replay_mem.sv
// Replay window storage: DEPTH entries, one synchronous write port, one asynchronous
// read port. Storage is deliberately not reset.
module order_replay_mem import order_replay_pkg::*; (
  input  logic            clk,
  input  logic            we_i,
  input  logic [ID_W-1:0] waddr_i,
  input  entry_t          wdata_i,
  input  logic [ID_W-1:0] raddr_i,
  output entry_t          rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/order_replay_buffer.sv
// Order-id allocator and go-back-N replay window feeding the dispatch stage.
// Optional accepted-resend counter on replay_cnt_o when ORDER_REPLAY_STATS_EN is defined.
module order_replay_buffer import order_replay_pkg::*; (
  input  logic                  clk,
  input  logic                  rst_n,
  order_replay_buffer_if.slave  bus,
  output logic                  err_o,
  output logic [15:0]           replay_cnt_o
);

  localparam logic [0:0] ST_RUN    = 1'(RUN);
  localparam logic [0:0] ST_REPLAY = 1'(REPLAY);

  logic [ID_W-1:0] head_q, head_d;
  logic [ID_W-1:0] tail_q, tail_d;
  logic [ID_W-1:0] rp_q, rp_d;
  logic [ID_W:0]   count_q, count_d;
  logic [0:0]      state_q, state_d;

  entry_t          out_q, out_d;
  logic            vld_q, vld_d;
  logic [ID_W-1:0] oid_q, oid_d;
  logic            err_q, err_d;

  logic            accept;
  logic            ret_ok;
  logic            res_ok;
  logic [ID_W-1:0] ret_off;
  logic [ID_W-1:0] rp_off;
  logic [ID_W-1:0] head_ret;
  logic [ID_W:0]   count_ret;
  logic [ID_W-1:0] rp_eff;
  entry_t          in_entry;
  entry_t          rd_entry;

  // count_q[ID_W] is set exactly when the window holds DEPTH entries.
  assign bus.in_ready = rst_n && (state_q == ST_RUN) && !count_q[ID_W] && !bus.resend_en;

  assign in_entry = '{data: bus.in_data, key_index: bus.in_key_index, target_id: bus.in_target_id};

  order_replay_mem u_mem (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (tail_q),
    .wdata_i (in_entry),
    .raddr_i (rp_eff),
    .rdata_o (rd_entry)
  );

  always_comb begin
    accept    = bus.in_vld && bus.in_ready;
    ret_off   = bus.ret_id - head_q;
    rp_off    = rp_q - head_q;
    ret_ok    = bus.ret_vld && in_window(bus.ret_id, head_q, count_q);
    head_ret  = ret_ok ? bus.ret_id + 1'b1 : head_q;
    count_ret = ret_ok ? count_q - {1'b0, ret_off} - 1'b1 : count_q;
    // Resend validity is judged against the window left after a same-cycle retire.
    res_ok    = bus.resend_en && in_window(bus.resend_id, head_ret, count_ret);
    err_d     = (bus.ret_vld && !ret_ok) || (bus.resend_en && !res_ok);
    rp_eff    = (ret_ok && (rp_off <= ret_off)) ? head_ret : rp_q;

    head_d  = head_ret;
    tail_d  = tail_q;
    count_d = count_ret + {{ID_W{1'b0}}, accept};
    state_d = state_q;
    rp_d    = rp_q;
    vld_d   = 1'b0;
    out_d   = out_q;
    oid_d   = oid_q;

    if (res_ok) begin
      state_d = ST_REPLAY;
      rp_d    = bus.resend_id;
    end else if (state_q == ST_RUN) begin
      if (accept) begin
        vld_d  = 1'b1;
        out_d  = in_entry;
        oid_d  = tail_q;
        tail_d = tail_q + 1'b1;
      end
    end else if (count_ret == '0) begin
      state_d = ST_RUN;
    end else begin
      vld_d = 1'b1;
      out_d = rd_entry;
      oid_d = rp_eff;
      rp_d  = rp_eff + 1'b1;
      if (rp_eff == tail_q - 1'b1) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      rp_q    <= '0;
      count_q <= '0;
      state_q <= ST_RUN;
      out_q   <= '0;
      vld_q   <= 1'b0;
      oid_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      state_q <= state_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      oid_q   <= oid_d;
      err_q   <= err_d;
    end
  end

  assign bus.test_data     = out_q.data;
  assign bus.key_index     = out_q.key_index;
  assign bus.target_id     = out_q.target_id;
  assign bus.test_data_vld = vld_q;
  assign bus.order_id      = oid_q;
  assign err_o             = err_q;

`ifdef ORDER_REPLAY_STATS_EN
  logic [15:0] replay_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_cnt_q <= '0;
    end else if (res_ok && (replay_cnt_q != 16'hFFFF)) begin
      replay_cnt_q <= replay_cnt_q + 16'd1;
    end
  end

  assign replay_cnt_o = replay_cnt_q;
`else
  assign replay_cnt_o = '0;
`endif

endmodule

// File: tb/tb_order_replay_buffer.sv
// Directed bench for order_replay_buffer: expected beats (cycle, id, payload) are queued
// when stimulus is driven and checked by a monitor when the DUT issues them.
module tb_order_replay_buffer;
  import order_replay_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_o;
  logic [15:0] replay_cnt;

  order_replay_buffer_if bus ();

  order_replay_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .err_o        (err_o),
    .replay_cnt_o (replay_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_c = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  id;
    logic [31:0] data;
    logic [2:0]  key;
    logic        tgt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_data [16];
  logic [2:0]  m_key  [16];
  logic        m_tgt  [16];
  logic [3:0]  tb_tail = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] id, input int at);
    q.push_back('{cyc: at, id: id, data: m_data[id], key: m_key[id], tgt: m_tgt[id]});
  endtask

  // Drop expected beats that a restart or retire cancels.
  task automatic flush_from(input int lim);
    while (q.size() > 0 && q[q.size()-1].cyc >= lim) void'(q.pop_back());
  endtask

  always @(negedge clk) begin
    logic due;
    exp_t e;
    if (rst_n) begin
      due = (q.size() > 0) && (q[0].cyc <= cyc);
      if (due || bus.test_data_vld) begin
        chk("beat_valid", 32'(bus.test_data_vld), due ? 32'd1 : 32'd0);
        if (bus.test_data_vld && q.size() > 0) begin
          e = q.pop_front();
          $display("beat cyc=%0d id=%0d data=%h key=%0d tgt=%0d", cyc, bus.order_id,
                   bus.test_data, bus.key_index, bus.target_id);
          chk("beat_cycle", 32'(cyc), 32'(e.cyc));
          chk("beat_order_id", 32'(bus.order_id), 32'(e.id));
          chk("beat_data", bus.test_data, e.data);
          chk("beat_key", 32'(bus.key_index), 32'(e.key));
          chk("beat_target", 32'(bus.target_id), 32'(e.tgt));
        end else if (due) begin
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    bus.in_vld = 1'b1; bus.in_data = '0; bus.in_key_index = '0; bus.in_target_id = 1'b0;
    bus.resend_en = 1'b0; bus.resend_id = '0; bus.ret_vld = 1'b0; bus.ret_id = '0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_vld", 32'(bus.test_data_vld), 32'd0);
    chk("rst_order_id", 32'(bus.order_id), 32'd0);
    chk("rst_test_data", bus.test_data, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_replay_cnt", 32'(replay_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_vld = 1'b0;
    tb_tail = 4'd0;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    $display("reset done cyc=%0d", cyc);
  endtask

  task automatic burst(input int n, input logic [31:0] base);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      bus.in_vld       = 1'b1;
      bus.in_data      = base + 32'(k);
      bus.in_key_index = 3'(k);
      bus.in_target_id = 1'(k);
      @(negedge clk);
      chk("in_ready_accept", 32'(bus.in_ready), 32'd1);
      m_data[tb_tail] = bus.in_data;
      m_key[tb_tail]  = bus.in_key_index;
      m_tgt[tb_tail]  = bus.in_target_id;
      push_exp(tb_tail, cyc + 1);
      $display("accept id=%0d data=%h", tb_tail, bus.in_data);
      tb_tail = tb_tail + 4'd1;
      @(posedge clk); #1;
    end
    bus.in_vld = 1'b0;
  endtask

  task automatic resend(input logic [3:0] id, input bit valid);
    logic [3:0] idx;
    int k;
    @(posedge clk); #1;
    bus.resend_en = 1'b1;
    bus.resend_id = id;
    @(negedge clk);
    last_c = cyc;
    chk("in_ready_during_resend", 32'(bus.in_ready), 32'd0);
    if (valid) begin
      flush_from(last_c + 1);
      idx = id;
      k = 0;
      do begin
        push_exp(idx, last_c + 2 + k);
        idx = idx + 4'd1;
        k++;
      end while (idx != tb_tail);
    end
    $display("resend id=%0d valid=%0d", id, valid);
    @(posedge clk); #1;
    bus.resend_en = 1'b0;
    @(negedge clk);
    chk("err_resend", 32'(err_o), valid ? 32'd0 : 32'd1);
  endtask

  task automatic retire(input logic [3:0] id, input bit exp_err);
    @(posedge clk); #1;
    bus.ret_vld = 1'b1;
    bus.ret_id  = id;
    @(negedge clk);
    $display("retire id=%0d", id);
    @(posedge clk); #1;
    bus.ret_vld = 1'b0;
    @(negedge clk);
    chk("err_retire", 32'(err_o), exp_err ? 32'd1 : 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_vld = 1'b0; bus.in_data = '0; bus.in_key_index = '0; bus.in_target_id = 1'b0;
    bus.resend_en = 1'b0; bus.resend_id = '0; bus.ret_vld = 1'b0; bus.ret_id = '0;

    // Accept, fill to full, retire, wrap tail, single-entry replay.
    do_reset();
    burst(3, 32'hA0);
    drain();
    burst(13, 32'hB0);
    @(negedge clk);
    chk("in_ready_full", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.in_vld = 1'b1;
    @(negedge clk);
    chk("in_ready_full_vld", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    retire(4'd3, 1'b0);
    chk("in_ready_after_retire", 32'(bus.in_ready), 32'd1);
    drain();
    burst(1, 32'hC0);
    drain();
    retire(4'd15, 1'b0);
    resend(4'd0, 1'b1);
    drain();
    resend(4'd1, 1'b0);

    // Go-back-N from id 2 of 0..5, source stalled throughout.
    do_reset();
    burst(6, 32'hD0);
    drain();
    resend(4'd2, 1'b1);
    chk("in_ready_replay", 32'(bus.in_ready), 32'd0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("in_ready_replay", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    chk("in_ready_back_to_run", 32'(bus.in_ready), 32'd1);
    drain();

    // Out-of-window resend and retire.
    do_reset();
    burst(4, 32'hE0);
    drain();
    resend(4'd9, 1'b0);
    @(negedge clk);
    chk("err_single_pulse", 32'(err_o), 32'd0);
    retire(4'd7, 1'b1);
    resend(4'd0, 1'b1);
    drain();

    // Retire overtaking the replay pointer.
    do_reset();
    burst(8, 32'h50);
    drain();
    resend(4'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.ret_vld = 1'b1;
    bus.ret_id  = 4'd5;
    @(negedge clk);
    flush_from(cyc + 1);
    push_exp(4'd6, cyc + 1);
    push_exp(4'd7, cyc + 2);
    @(posedge clk); #1;
    bus.ret_vld = 1'b0;
    @(negedge clk);
    chk("err_retire_in_replay", 32'(err_o), 32'd0);
    drain();
    chk("in_ready_after_replay", 32'(bus.in_ready), 32'd1);

    // Restart during replay, resend statistics, reset mid-replay.
    do_reset();
    burst(4, 32'h60);
    drain();
    resend(4'd0, 1'b1);
    resend(4'd2, 1'b1);
    drain();
    resend(4'd8, 1'b0);
    resend(4'd3, 1'b1);
    drain();
`ifdef ORDER_REPLAY_STATS_EN
    chk("replay_cnt", 32'(replay_cnt), 32'd3);
`else
    chk("replay_cnt", 32'(replay_cnt), 32'd0);
`endif
    resend(4'd0, 1'b1);
    do_reset();
    resend(4'd0, 1'b0);
    burst(1, 32'h70);
    drain();

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
